// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t : FSM state encoding (IDLE/RUN/DONE, 2 bits)
//   cnt_w() : iteration counter width for a given operand width
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wide enough to hold BUS_WIDTH itself, the "all iterations done" value.
  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// A request is accepted in IDLE, runs BUS_WIDTH iterations, spends one more
// edge applying the sign, then presents a single-cycle done pulse.
// Ports:
//   clk, rst        clock, async active-high reset
//   start           request, honoured only while busy=0
//   sgn             1 = two's-complement operands, 0 = unsigned (sampled with start)
//   a, b            multiplicand / multiplier (sampled with start)
//   busy            high from the accepting edge through the done cycle
//   done            one-cycle pulse, result valid (drives downstream register enable)
//   out_lo, out_hi  product halves, held until the next product completes
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] out_lo,
  output logic [BUS_WIDTH-1:0] out_hi
);

  localparam int W  = BUS_WIDTH;
  localparam int CW = cnt_w(W);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    mcand, mplier;
  logic [2*W-1:0]  acc;
  logic            neg;

  logic            iter_done;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      sum;
  logic [2*W-1:0]  prod;

  // Counter reaches W once the last iteration (cnt == W-1) has been applied.
  assign iter_done = (cnt == CW'(W));

  // Signed operands are reduced to magnitudes; |most-negative| still fits W bits.
  assign a_mag = (sgn && a[W-1]) ? -a : a;
  assign b_mag = (sgn && b[W-1]) ? -b : b;

  // W+1-bit add into the upper half keeps the carry for the following shift.
  assign sum  = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign prod = neg ? -acc : acc;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (iter_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      out_lo <= '0;
      out_hi <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mcand  <= a_mag;
          mplier <= b_mag;
          neg    <= sgn & (a[W-1] ^ b[W-1]);
          acc    <= '0;
          cnt    <= '0;
        end
        S_RUN: if (iter_done) begin
          out_hi <= prod[2*W-1:W];
          out_lo <= prod[W-1:0];
        end else begin
          // Shift {carry, upper sum, lower half} right one; product bits drop into the low half.
          acc    <= {sum, acc[W-1:1]};
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0, sgn = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done;
  logic [W-1:0] out_lo, out_hi;

  logic         start32 = 1'b0, sgn32 = 1'b0;
  logic [31:0]  a32 = '0, b32 = '0;
  logic         busy32, done32;
  logic [31:0]  lo32, hi32, cap32;

  seq_multiplier #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .busy(busy), .done(done), .out_lo(out_lo), .out_hi(out_hi)
  );

  seq_multiplier #(.BUS_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .sgn(sgn32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .out_lo(lo32), .out_hi(hi32)
  );

  // Downstream result register enabled by done.
  always @(posedge clk or posedge rst)
    if (rst) cap32 <= '0;
    else if (done32) cap32 <= lo32;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc_cyc;
  } exp_t;

  exp_t           q[$];
  int             checks = 0, failures = 0;
  int             cyc = 0, busy_cnt = 0, last_done_cyc = -100;
  logic [2*W-1:0] last = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  // Reference: plain integer product of the interpreted operands.
  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int sx, sy, p;
    sx = s ? int'($signed(x)) : int'(x);
    sy = s ? int'($signed(y)) : int'(y);
    p  = sx * sy;
    return p[2*W-1:0];
  endfunction

  // Monitor: compare on done, and check outputs hold steady otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy) busy_cnt = busy_cnt + 1;
      else      busy_cnt = 0;
      if (done) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("product", {out_hi, out_lo}, e.prod);
          chk("latency", cyc, e.acc_cyc + W + 1);
          chk("busy_len", busy_cnt, W + 2);
          last = e.prod;
        end
        last_done_cyc = cyc;
      end else begin
        chk("hold", {out_hi, out_lo}, last);
      end
    end
  end

  task automatic push_exp(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.prod    = ref_mul(s, x, y);
    e.acc_cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic issue(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin @(negedge clk); n++; end
    if (busy) begin
      chk("issue_timeout", 1, 0);
      return;
    end
    sgn = s; a = x; b = y; start = 1'b1;
    push_exp(s, x, y);
    @(negedge clk);
    start = 1'b0;
    // Operand changes after acceptance must not matter.
    a = W'($urandom); b = W'($urandom); sgn = ~s;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 60) begin @(negedge clk); n++; end
    if (q.size() != 0 || busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int accepted;
    logic s;
    logic [W-1:0] x, y;

    #1;
    chk("rst_lo", out_lo, 0);
    chk("rst_hi", out_hi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    issue(1'b0, 8'd13, 8'd11);  wait_idle();
    issue(1'b1, 8'hF6, 8'd7);   wait_idle();
    issue(1'b0, 8'hF6, 8'd7);   wait_idle();
    issue(1'b1, 8'h80, 8'h80);  wait_idle();
    issue(1'b0, 8'hFF, 8'hFF);  wait_idle();
    issue(1'b1, 8'h00, 8'h85);  wait_idle();
    issue(1'b1, 8'h7F, 8'h80);  wait_idle();
    chk("dir_16b_last", {out_hi, out_lo}, 16'hC080);

    // Start held/repulsed through RUN and DONE: only IDLE-edge acceptances count.
    issue(1'b0, 8'd200, 8'd3);
    accepted = 0;
    for (int i = 0; i < 40 && accepted < 1; i++) begin
      @(negedge clk);
      s = 1'($urandom); x = W'($urandom); y = W'($urandom);
      if (!busy) begin
        chk("accept_after_done", cyc, last_done_cyc + 1);
        push_exp(s, x, y);
        accepted++;
      end
      sgn = s; a = x; b = y; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_accepted", accepted, 1);
    wait_idle();

    // Reset in the middle of RUN.
    issue(1'b0, 8'd99, 8'd77);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_lo", out_lo, 0);
    chk("abort_hi", out_hi, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    q.delete();
    last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);  // no done may appear here
    issue(1'b1, 8'hE3, 8'h19);  wait_idle();

    // Random back-to-back traffic.
    for (int i = 0; i < 30; i++) begin
      x = (i % 7 == 0) ? 8'h00 : W'($urandom);
      issue(1'($urandom), x, W'($urandom));
    end
    wait_idle();

    // 32-bit smoke run with a done-enabled capture register.
    @(negedge clk);
    a32 = 32'hFFFF_FFFF; b32 = 32'h2; sgn32 = 1'b0; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; a32 = '0; b32 = '0;
    begin
      int n = 0;
      while (!done32 && n < 60) begin @(negedge clk); n++; end
    end
    chk("w32_done", done32, 1);
    chk("w32_hi", hi32, 32'h1);
    chk("w32_lo", lo32, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("w32_cap", cap32, 32'hFFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
